// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling and a bubble counter.
// Optional writeback-to-operand bypass is compiled in by defining WB_BYPASS_EN.
module id_ex_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CTRL_W = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ID_VALID,
   input  logic [4:0]        ID_RS1,
   input  logic [4:0]        ID_RS2,
   input  logic [4:0]        ID_RD,
   input  logic              ID_USES_RS1,
   input  logic              ID_USES_RS2,
   input  logic [XLEN-1:0]   ID_PC,
   input  logic [XLEN-1:0]   ID_IMM,
   input  logic [CTRL_W-1:0] ID_CTRL,
   input  logic              ID_MEM_READ,
   input  logic [XLEN-1:0]   RD_DATA1,
   input  logic [XLEN-1:0]   RD_DATA2,
   input  logic              WB_WE,
   input  logic [4:0]        WB_ADDR,
   input  logic [XLEN-1:0]   WB_DATA,
   input  logic              FLUSH,
   input  logic              EX_HOLD,
   output logic              STALL_OUT,
   output logic              EX_VALID,
   output logic [4:0]        EX_RS1,
   output logic [4:0]        EX_RS2,
   output logic [4:0]        EX_RD,
   output logic [XLEN-1:0]   EX_OP1,
   output logic [XLEN-1:0]   EX_OP2,
   output logic [XLEN-1:0]   EX_PC,
   output logic [XLEN-1:0]   EX_IMM,
   output logic [CTRL_W-1:0] EX_CTRL,
   output logic              EX_MEM_READ,
   output logic [15:0]       BUBBLE_CNT
);

   typedef enum logic [1:0] {
      ACT_FLUSH,
      ACT_HOLD,
      ACT_BUBBLE,
      ACT_CAPTURE
   } action_e;

   logic              ex_valid_q, ex_valid_d;
   logic [4:0]        ex_rs1_q, ex_rs1_d;
   logic [4:0]        ex_rs2_q, ex_rs2_d;
   logic [4:0]        ex_rd_q, ex_rd_d;
   logic [XLEN-1:0]   ex_op1_q, ex_op1_d;
   logic [XLEN-1:0]   ex_op2_q, ex_op2_d;
   logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
   logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic [15:0]       bubble_cnt_q, bubble_cnt_d;

   logic              hazard;
   action_e           action;
   logic [XLEN-1:0]   op1_sel, op2_sel;
   logic [XLEN-1:0]   op1_hold, op2_hold;

   always_comb begin
      hazard = ID_VALID & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) &
               ((ID_USES_RS1 & (ID_RS1 == ex_rd_q)) | (ID_USES_RS2 & (ID_RS2 == ex_rd_q)));
   end

   assign STALL_OUT = hazard | EX_HOLD;

   always_comb begin
      action = ACT_CAPTURE;
      if (FLUSH) begin
         action = ACT_FLUSH;
      end else if (EX_HOLD) begin
         action = ACT_HOLD;
      end else if (hazard) begin
         action = ACT_BUBBLE;
      end
   end

   // Register x0 always reads as zero, ahead of any bypass.
   always_comb begin
      op1_sel  = RD_DATA1;
      op2_sel  = RD_DATA2;
      op1_hold = ex_op1_q;
      op2_hold = ex_op2_q;
`ifdef WB_BYPASS_EN
      if (WB_WE && (WB_ADDR == ID_RS1)) op1_sel = WB_DATA;
      if (WB_WE && (WB_ADDR == ID_RS2)) op2_sel = WB_DATA;
      if (ex_valid_q && WB_WE && (WB_ADDR == ex_rs1_q) && (ex_rs1_q != 5'd0)) op1_hold = WB_DATA;
      if (ex_valid_q && WB_WE && (WB_ADDR == ex_rs2_q) && (ex_rs2_q != 5'd0)) op2_hold = WB_DATA;
`endif
      if (ID_RS1 == 5'd0) op1_sel = '0;
      if (ID_RS2 == 5'd0) op2_sel = '0;
   end

`ifndef WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{WB_WE, WB_ADDR, WB_DATA};
`endif

   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rd_d       = ex_rd_q;
      ex_op1_d      = ex_op1_q;
      ex_op2_d      = ex_op2_q;
      ex_pc_d       = ex_pc_q;
      ex_imm_d      = ex_imm_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_mem_read_d = ex_mem_read_q;
      bubble_cnt_d  = bubble_cnt_q;
      unique case (action)
         ACT_FLUSH, ACT_BUBBLE: begin
            ex_valid_d    = 1'b0;
            ex_rs1_d      = '0;
            ex_rs2_d      = '0;
            ex_rd_d       = '0;
            ex_op1_d      = '0;
            ex_op2_d      = '0;
            ex_pc_d       = '0;
            ex_imm_d      = '0;
            ex_ctrl_d     = '0;
            ex_mem_read_d = 1'b0;
            if ((action == ACT_BUBBLE) && (bubble_cnt_q != '1)) begin
               bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
         end
         ACT_HOLD: begin
            ex_op1_d = op1_hold;
            ex_op2_d = op2_hold;
         end
         ACT_CAPTURE: begin
            ex_valid_d    = ID_VALID;
            ex_rs1_d      = ID_RS1;
            ex_rs2_d      = ID_RS2;
            ex_rd_d       = ID_RD;
            ex_op1_d      = op1_sel;
            ex_op2_d      = op2_sel;
            ex_pc_d       = ID_PC;
            ex_imm_d      = ID_IMM;
            ex_ctrl_d     = ID_CTRL;
            ex_mem_read_d = ID_MEM_READ;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_valid_q    <= 1'b0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         ex_op1_q      <= '0;
         ex_op2_q      <= '0;
         ex_pc_q       <= '0;
         ex_imm_q      <= '0;
         ex_ctrl_q     <= '0;
         ex_mem_read_q <= 1'b0;
         bubble_cnt_q  <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_op1_q      <= ex_op1_d;
         ex_op2_q      <= ex_op2_d;
         ex_pc_q       <= ex_pc_d;
         ex_imm_q      <= ex_imm_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_mem_read_q <= ex_mem_read_d;
         bubble_cnt_q  <= bubble_cnt_d;
      end
   end

   assign EX_VALID    = ex_valid_q;
   assign EX_RS1      = ex_rs1_q;
   assign EX_RS2      = ex_rs2_q;
   assign EX_RD       = ex_rd_q;
   assign EX_OP1      = ex_op1_q;
   assign EX_OP2      = ex_op2_q;
   assign EX_PC       = ex_pc_q;
   assign EX_IMM      = ex_imm_q;
   assign EX_CTRL     = ex_ctrl_q;
   assign EX_MEM_READ = ex_mem_read_q;
   assign BUBBLE_CNT  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_id_ex_stage;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned CTRL_W = 16;

   logic              CLK, RESET, ID_VALID, ID_USES_RS1, ID_USES_RS2, ID_MEM_READ;
   logic [4:0]        ID_RS1, ID_RS2, ID_RD, WB_ADDR;
   logic [XLEN-1:0]   ID_PC, ID_IMM, RD_DATA1, RD_DATA2, WB_DATA;
   logic [CTRL_W-1:0] ID_CTRL;
   logic              WB_WE, FLUSH, EX_HOLD, STALL_OUT;
   logic              EX_VALID, EX_MEM_READ;
   logic [4:0]        EX_RS1, EX_RS2, EX_RD;
   logic [XLEN-1:0]   EX_OP1, EX_OP2, EX_PC, EX_IMM;
   logic [CTRL_W-1:0] EX_CTRL;
   logic [15:0]       BUBBLE_CNT;

   typedef struct packed {
      logic              valid;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [CTRL_W-1:0] ctrl;
      logic              mr;
   } ex_t;

   ex_t         m;
   int unsigned m_cnt;
   int          errors = 0;
   int          checks = 0;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .CLK(CLK), .RESET(RESET), .ID_VALID(ID_VALID),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .ID_PC(ID_PC), .ID_IMM(ID_IMM), .ID_CTRL(ID_CTRL), .ID_MEM_READ(ID_MEM_READ),
      .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
      .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .FLUSH(FLUSH), .EX_HOLD(EX_HOLD), .STALL_OUT(STALL_OUT),
      .EX_VALID(EX_VALID), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
      .EX_OP1(EX_OP1), .EX_OP2(EX_OP2), .EX_PC(EX_PC), .EX_IMM(EX_IMM),
      .EX_CTRL(EX_CTRL), .EX_MEM_READ(EX_MEM_READ), .BUBBLE_CNT(BUBBLE_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic ex_t dut_view();
      return {EX_VALID, EX_RS1, EX_RS2, EX_RD, EX_OP1, EX_OP2, EX_PC, EX_IMM, EX_CTRL, EX_MEM_READ};
   endfunction

   function automatic logic [XLEN-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // A load sits in EX and the decoding instruction really reads its destination.
   function automatic bit model_hazard();
      if (!(ID_VALID && m.valid && m.mr && m.rd != 5'd0)) return 1'b0;
      return (ID_USES_RS1 && ID_RS1 == m.rd) || (ID_USES_RS2 && ID_RS2 == m.rd);
   endfunction

   function automatic logic [XLEN-1:0] src_value(input logic [4:0] rs, input logic [XLEN-1:0] rf);
      if (rs == 5'd0) return '0;
`ifdef WB_BYPASS_EN
      if (WB_WE && WB_ADDR == rs) return WB_DATA;
`endif
      return rf;
   endfunction

   task automatic advance();
      ex_t         n;
      int unsigned c;
      n = m;
      c = m_cnt;
      if (RESET) begin
         n = '0;
         c = 0;
      end else if (FLUSH) begin
         n = '0;
      end else if (EX_HOLD) begin
`ifdef WB_BYPASS_EN
         if (m.valid && WB_WE && WB_ADDR == m.rs1 && m.rs1 != 5'd0) n.op1 = WB_DATA;
         if (m.valid && WB_WE && WB_ADDR == m.rs2 && m.rs2 != 5'd0) n.op2 = WB_DATA;
`endif
      end else if (model_hazard()) begin
         n = '0;
         c = (c < 65535) ? c + 1 : 65535;
      end else begin
         n.valid = ID_VALID;
         n.rs1   = ID_RS1;
         n.rs2   = ID_RS2;
         n.rd    = ID_RD;
         n.op1   = src_value(ID_RS1, RD_DATA1);
         n.op2   = src_value(ID_RS2, RD_DATA2);
         n.pc    = ID_PC;
         n.imm   = ID_IMM;
         n.ctrl  = ID_CTRL;
         n.mr    = ID_MEM_READ;
      end
      @(posedge CLK);
      #1;
      m     = n;
      m_cnt = c;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic mr);
      ID_VALID    = v;
      ID_RS1      = rs1;
      ID_RS2      = rs2;
      ID_RD       = rd;
      ID_USES_RS1 = u1;
      ID_USES_RS2 = u2;
      ID_MEM_READ = mr;
      ID_PC       = rnd64();
      ID_IMM      = rnd64();
      ID_CTRL     = CTRL_W'($urandom);
      RD_DATA1    = rnd64();
      RD_DATA2    = rnd64();
   endtask

   task automatic quiet_ctrl();
      RESET = 1'b0; FLUSH = 1'b0; EX_HOLD = 1'b0; WB_WE = 1'b0; WB_ADDR = 5'd0; WB_DATA = '0;
   endtask

   task automatic test_reset();
      quiet_ctrl();
      set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1);
      RESET = 1'b1;
      #1;
      advance();
      checks++;
      if (dut_view() !== ex_t'('0)) begin
         errors++; $display("FAIL reset_ex: got %h want 0", dut_view());
      end
      checks++;
      if (BUBBLE_CNT !== 16'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d want 0", BUBBLE_CNT);
      end
      checks++;
      if (STALL_OUT !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b want 0", STALL_OUT);
      end
      RESET = 1'b0;
   endtask

   task automatic test_load_use();
      logic [XLEN-1:0] pc_use;
      quiet_ctrl();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
      #1; advance();
      set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
      pc_use = ID_PC;
      #1;
      checks++;
      if (STALL_OUT !== 1'b1) begin
         errors++; $display("FAIL loaduse_stall: got %b want 1", STALL_OUT);
      end
      advance();
      checks++;
      if (EX_VALID !== 1'b0 || BUBBLE_CNT !== 16'd1) begin
         errors++; $display("FAIL loaduse_bubble: got valid=%b cnt=%0d want valid=0 cnt=1", EX_VALID, BUBBLE_CNT);
      end
      checks++;
      if (STALL_OUT !== 1'b0) begin
         errors++; $display("FAIL loaduse_release: got %b want 0", STALL_OUT);
      end
      advance();
      checks++;
      if (EX_VALID !== 1'b1 || EX_PC !== pc_use || EX_RS1 !== 5'd5) begin
         errors++; $display("FAIL loaduse_capture: got valid=%b pc=%h rs1=%0d want 1 %h 5", EX_VALID, EX_PC, EX_RS1, pc_use);
      end
   endtask

   task automatic test_false_hazard();
      quiet_ctrl();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
      #1; advance();
      set_id(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (STALL_OUT !== 1'b0) begin
         errors++; $display("FAIL false_unused_stall: got %b want 0", STALL_OUT);
      end
      advance();
      checks++;
      if (EX_VALID !== 1'b1 || BUBBLE_CNT !== 16'(m_cnt) || dut_view() !== m) begin
         errors++; $display("FAIL false_unused_capture: got %h cnt=%0d want %h cnt=%0d", dut_view(), BUBBLE_CNT, m, m_cnt);
      end
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1);
      #1; advance();
      set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
      #1;
      checks++;
      if (STALL_OUT !== 1'b0) begin
         errors++; $display("FAIL false_rd0_stall: got %b want 0", STALL_OUT);
      end
      advance();
      checks++;
      if (EX_VALID !== 1'b1 || EX_OP1 !== '0 || EX_OP2 !== '0 || BUBBLE_CNT !== 16'(m_cnt)) begin
         errors++; $display("FAIL false_rd0_capture: got valid=%b op1=%h op2=%h cnt=%0d", EX_VALID, EX_OP1, EX_OP2, BUBBLE_CNT);
      end
   endtask

   task automatic test_flush_hold();
      ex_t held;
      quiet_ctrl();
      set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
      #1; advance();
      held = m;
      set_id(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0);
      EX_HOLD = 1'b1;
      #1;
      checks++;
      if (STALL_OUT !== 1'b1) begin
         errors++; $display("FAIL hold_stall: got %b want 1", STALL_OUT);
      end
      advance();
      checks++;
      if (dut_view() !== held) begin
         errors++; $display("FAIL hold_keep: got %h want %h", dut_view(), held);
      end
      FLUSH = 1'b1;
      #1; advance();
      checks++;
      if (EX_VALID !== 1'b0 || EX_PC !== '0 || dut_view() !== ex_t'('0)) begin
         errors++; $display("FAIL flush_over_hold: got %h want 0", dut_view());
      end
      quiet_ctrl();
      set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1);
      #1; advance();
      EX_HOLD = 1'b1; RESET = 1'b1;
      #1; advance();
      checks++;
      if (dut_view() !== ex_t'('0) || BUBBLE_CNT !== 16'd0) begin
         errors++; $display("FAIL reset_mid_hold: got %h cnt=%0d want 0", dut_view(), BUBBLE_CNT);
      end
      quiet_ctrl();
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] want;
      quiet_ctrl();
      set_id(1'b1, 5'd2, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
      RD_DATA2 = 64'h11;
      WB_WE = 1'b1; WB_ADDR = 5'd7; WB_DATA = 64'h22;
`ifdef WB_BYPASS_EN
      want = 64'h22;
`else
      want = 64'h11;
`endif
      #1; advance();
      checks++;
      if (EX_OP2 !== want) begin
         errors++; $display("FAIL bypass_op2: got %h want %h", EX_OP2, want);
      end
      set_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
      WB_ADDR = 5'd0; WB_DATA = 64'h33;
      #1; advance();
      checks++;
      if (EX_OP1 !== '0 || EX_OP2 !== '0) begin
         errors++; $display("FAIL bypass_x0: got op1=%h op2=%h want 0 0", EX_OP1, EX_OP2);
      end
      set_id(1'b1, 5'd6, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0);
      WB_WE = 1'b0;
      #1; advance();
      EX_HOLD = 1'b1; WB_WE = 1'b1; WB_ADDR = 5'd6; WB_DATA = 64'h44;
      #1; advance();
      checks++;
      if (dut_view() !== m) begin
         errors++; $display("FAIL bypass_hold_refresh: got %h want %h", dut_view(), m);
      end
      quiet_ctrl();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         RESET       = ($urandom_range(0, 63) == 0);
         FLUSH       = ($urandom_range(0, 15) == 0);
         EX_HOLD     = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
         WB_WE   = 1'($urandom);
         WB_ADDR = 5'($urandom_range(0, 7));
         WB_DATA = rnd64();
         #1;
         checks++;
         if (STALL_OUT !== (model_hazard() || EX_HOLD)) begin
            errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, STALL_OUT, model_hazard() || EX_HOLD);
         end
         advance();
         checks++;
         if (dut_view() !== m || BUBBLE_CNT !== 16'(m_cnt)) begin
            errors++; $display("FAIL rand_ex[%0d]: got %h cnt=%0d want %h cnt=%0d", i, dut_view(), BUBBLE_CNT, m, m_cnt);
         end
      end
      quiet_ctrl();
   endtask

   // Two cycles per bubble: capture the load, then the dependent instruction bubbles.
   task automatic test_saturation();
      quiet_ctrl();
      RESET = 1'b1;
      #1; advance();
      RESET = 1'b0;
      set_id(1'b1, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2 * 65540; i++) begin
         advance();
         if (i == 1999) begin
            checks++;
            if (BUBBLE_CNT !== 16'd1000) begin
               errors++; $display("FAIL sat_midway: got %0d want 1000", BUBBLE_CNT);
            end
         end
      end
      checks++;
      if (BUBBLE_CNT !== 16'hFFFF || m_cnt != 65535) begin
         errors++; $display("FAIL sat_reach: got %h want ffff", BUBBLE_CNT);
      end
      for (int i = 0; i < 6; i++) advance();
      checks++;
      if (BUBBLE_CNT !== 16'hFFFF) begin
         errors++; $display("FAIL sat_stay: got %h want ffff", BUBBLE_CNT);
      end
   endtask

   initial begin
      m = '0;
      m_cnt = 0;
      quiet_ctrl();
      RESET = 1'b1;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_load_use();
      test_false_hazard();
      test_flush_hold();
      test_bypass();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
